// File: rtl/tree_reduce_pkg.sv
// Shared definitions for the reduction-tree family: operator selection and
// per-level width arithmetic, so that the tree and its variants agree on bus sizes.
package tree_reduce_pkg;

    typedef enum logic [0:0] {
        OP_SUM = 1'b0,
        OP_MAX = 1'b1
    } op_e;

    // Width of the node outputs of level k (k = 0 is the leaf level).
    // A sum grows one bit per level so it can never overflow; a max keeps the operand width.
    function automatic int level_width(op_e op, int dw, int k);
        if (op == OP_SUM) begin
            return dw + k + 1;
        end else begin
            return dw;
        end
    endfunction

    // Width of the single root result.
    function automatic int out_width(op_e op, int dw, int levels);
        return level_width(op, dw, levels - 1);
    endfunction

endpackage

// File: rtl/tree_reduce_stage.sv
// One valid/ready register slice. It accepts whenever it is empty or its content
// is leaving this cycle, so bubbles collapse while the output is stalled.
module tree_reduce_stage #(
    parameter int Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [Width-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [Width-1:0] out_data_o
);

    logic             valid_q;
    logic             valid_d;
    logic             load_s;
    logic [Width-1:0] data_q;

    assign in_ready_o = ~valid_q | out_ready_i;
    assign load_s     = in_valid_i & in_ready_o & ~clear_i;

    // Next valid: flush on clear, refill or drain when ready, otherwise hold.
    always_comb begin
        valid_d = valid_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (in_ready_o) begin
            valid_d = in_valid_i;
        end else begin
            valid_d = valid_q;
        end
    end

    // Valid flag register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Data register, written only on an actual load so a stalled beat stays put.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= {Width{1'b0}};
        end else if (load_s) begin
            data_q <= in_data_i;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

endmodule

// File: rtl/tree_reduce_pipe.sv
// Binary reduction tree over 2**Levels operands (unsigned sum or max), with an
// optional valid/ready register slice after any level chosen by PipeMask.
module tree_reduce_pipe
    import tree_reduce_pkg::*;
#(
    parameter int              DataWidth = 8,
    parameter int              Levels    = 3,
    parameter op_e             Op        = OP_SUM,
    parameter logic [Levels-1:0] PipeMask = '1,
    localparam int             NumIn     = 2 ** Levels,
    localparam int             OutWidth  = out_width(Op, DataWidth, Levels)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clear_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [NumIn*DataWidth-1:0] in_data_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [OutWidth-1:0]        out_data_o,
    output logic                       busy_o
);

    // Handshake chain: index k is the boundary in front of level k, index Levels is the output.
    logic [Levels:0]   vld_s;
    logic [Levels:0]   rdy_s;
    logic [Levels-1:0] stg_busy_s;

    assign vld_s[0]      = in_valid_i;
    assign rdy_s[Levels] = out_ready_i;
    // While flushing nothing may enter, even in a fully combinational tree.
    assign in_ready_o    = rdy_s[0] & ~clear_i;

    if (Levels < 1) begin : g_chk_levels
        $error("tree_reduce_pipe: Levels must be >= 1");
    end
    if (DataWidth < 1) begin : g_chk_width
        $error("tree_reduce_pipe: DataWidth must be >= 1");
    end
    if ($bits(PipeMask) != Levels) begin : g_chk_mask
        $error("tree_reduce_pipe: PipeMask must have Levels bits");
    end

    for (genvar k = 0; k < Levels; k++) begin : g_lvl
        localparam int InW   = (k == 0) ? DataWidth : level_width(Op, DataWidth, k - 1);
        localparam int LvW   = level_width(Op, DataWidth, k);
        localparam int Nodes = 2 ** (Levels - 1 - k);

        logic [2*Nodes*InW-1:0] src_s;
        logic [Nodes*LvW-1:0]   node_s;
        logic [Nodes*LvW-1:0]   lvl_data_s;

        if (k == 0) begin : g_src_in
            assign src_s = in_data_i;
        end else begin : g_src_prev
            assign src_s = g_lvl[k-1].lvl_data_s;
        end

        for (genvar j = 0; j < Nodes; j++) begin : g_node
            logic [InW-1:0] left_s;
            logic [InW-1:0] right_s;

            assign left_s  = src_s[(2*j)*InW +: InW];
            assign right_s = src_s[(2*j+1)*InW +: InW];

            if (Op == OP_SUM) begin : g_sum
                assign node_s[j*LvW +: LvW] = {1'b0, left_s} + {1'b0, right_s};
            end else begin : g_max
                // Ties resolve to the left child.
                assign node_s[j*LvW +: LvW] = (right_s > left_s) ? right_s : left_s;
            end
        end

        if (PipeMask[k]) begin : g_stage
            tree_reduce_stage #(
                .Width(Nodes * LvW)
            ) u_stage (
                .clk_i      (clk_i),
                .rst_ni     (rst_ni),
                .clear_i    (clear_i),
                .in_valid_i (vld_s[k]),
                .in_ready_o (rdy_s[k]),
                .in_data_i  (node_s),
                .out_valid_o(vld_s[k+1]),
                .out_ready_i(rdy_s[k+1]),
                .out_data_o (lvl_data_s)
            );
            assign stg_busy_s[k] = vld_s[k+1];
        end else begin : g_pass
            assign vld_s[k+1]    = vld_s[k];
            assign rdy_s[k]      = rdy_s[k+1];
            assign lvl_data_s    = node_s;
            assign stg_busy_s[k] = 1'b0;
        end
    end

    assign out_valid_o = vld_s[Levels];
    assign out_data_o  = g_lvl[Levels-1].lvl_data_s;
    assign busy_o      = |stg_busy_s;

endmodule
